// File: rtl/countdown_timer.sv
// Countdown timer: loads a preset hh:mm:ss, counts down on the 1 Hz strobe, rings a rotating LED alarm.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN reloads the working count from the preset on ring exit.
module countdown_timer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SEC_RANGE  = 60,
  parameter int unsigned MIN_RANGE  = 60,
  parameter int unsigned HOUR_RANGE = 24,
  parameter int unsigned LEN        = 30,
  parameter int unsigned NUM        = 5
) (
  input  logic             clk_dst,
  input  logic             reset_n,
  input  logic             tick_1hz,
  input  logic             power,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [2:0]       add_time,
  input  logic [2:0]       sub_time,
  output logic [WIDTH-1:0] sec,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] hour,
  output logic             running,
  output logic             alarm_ring,
  output logic [NUM-1:0]   alarm_light
);

  localparam int unsigned CntW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [WIDTH-1:0] SecTop  = WIDTH'(SEC_RANGE - 1);
  localparam logic [WIDTH-1:0] MinTop  = WIDTH'(MIN_RANGE - 1);
  localparam logic [WIDTH-1:0] HourTop = WIDTH'(HOUR_RANGE - 1);
  localparam logic [WIDTH-1:0] One     = WIDTH'(1);

  typedef enum logic [1:0] {StSet, StRun, StPause, StRing} state_e;

  state_e state_q, state_d;

  logic             start_q, pause_q, clear_q;
  logic [2:0]       add_q, sub_q;
  logic [WIDTH-1:0] psec_q, pmin_q, phour_q, psec_d, pmin_d, phour_d;
  logic [WIDTH-1:0] wsec_q, wmin_q, whour_q, wsec_d, wmin_d, whour_d;
  logic [WIDTH-1:0] sec_q, min_q, hour_q, sec_d, min_d, hour_d;
  logic [CntW-1:0]  ring_cnt_q, ring_cnt_d;
  logic [NUM-1:0]   light_q, light_d;
  logic             running_q, running_d, ring_q, ring_d;

  logic             start_rise, pause_rise, clear_rise;
  logic [2:0]       add_rise, sub_rise;
  logic [WIDTH-1:0] dsec, dmin, dhour;
  logic             dec_zero, preset_zero, ring_last;

  assign start_rise  = start & ~start_q;
  assign pause_rise  = pause & ~pause_q;
  assign clear_rise  = clear & ~clear_q;
  assign add_rise    = add_time & ~add_q;
  assign sub_rise    = sub_time & ~sub_q;
  assign preset_zero = (psec_q == '0) && (pmin_q == '0) && (phour_q == '0);
  assign ring_last   = (ring_cnt_q == CntW'(LEN - 1));

  // Modular step of one preset field; simultaneous up and down cancel.
  function automatic logic [WIDTH-1:0] step_field(input logic [WIDTH-1:0] v, input logic up,
                                                  input logic dn, input logic [WIDTH-1:0] top);
    if (up && !dn) return (v == top) ? '0 : v + One;
    if (dn && !up) return (v == '0) ? top : v - One;
    return v;
  endfunction

  // Working value minus one second, with borrow across fields.
  always_comb begin
    dsec  = wsec_q - One;
    dmin  = wmin_q;
    dhour = whour_q;
    if (wsec_q == '0) begin
      dsec = SecTop;
      if (wmin_q == '0) begin
        dmin  = MinTop;
        dhour = whour_q - One;
      end else begin
        dmin = wmin_q - One;
      end
    end
  end

  assign dec_zero = (dsec == '0) && (dmin == '0) && (dhour == '0);

  // State register
  always_ff @(posedge clk_dst or negedge reset_n) begin
    if (!reset_n) state_q <= StSet;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!power || clear_rise) begin
      state_d = StSet;
    end else begin
      unique case (state_q)
        StSet:   if (start_rise) state_d = preset_zero ? StRing : StRun;
        StRun: begin
          if (!start_rise && pause_rise) state_d = StPause;
          else if (tick_1hz && dec_zero) state_d = StRing;
        end
        StPause: if (start_rise) state_d = StRun;
        StRing:  if (tick_1hz && ring_last) state_d = StSet;
        default: state_d = StSet;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    psec_d     = psec_q;
    pmin_d     = pmin_q;
    phour_d    = phour_q;
    wsec_d     = wsec_q;
    wmin_d     = wmin_q;
    whour_d    = whour_q;
    ring_cnt_d = ring_cnt_q;
    light_d    = light_q;
    if (!power || clear_rise) begin
      wsec_d     = psec_q;
      wmin_d     = pmin_q;
      whour_d    = phour_q;
      ring_cnt_d = '0;
      light_d    = '0;
    end else begin
      unique case (state_q)
        StSet: begin
          if (start_rise) begin
            wsec_d     = psec_q;
            wmin_d     = pmin_q;
            whour_d    = phour_q;
            ring_cnt_d = '0;
            light_d    = preset_zero ? NUM'(1) : '0;
          end else if ((add_rise != 3'b000) || (sub_rise != 3'b000)) begin
            psec_d  = step_field(psec_q, add_rise[0], sub_rise[0], SecTop);
            pmin_d  = step_field(pmin_q, add_rise[1], sub_rise[1], MinTop);
            phour_d = step_field(phour_q, add_rise[2], sub_rise[2], HourTop);
            wsec_d  = psec_d;
            wmin_d  = pmin_d;
            whour_d = phour_d;
          end
        end
        StRun: begin
          if (!(!start_rise && pause_rise) && tick_1hz) begin
            wsec_d  = dsec;
            wmin_d  = dmin;
            whour_d = dhour;
            if (dec_zero) begin
              ring_cnt_d = '0;
              light_d    = NUM'(1);
            end
          end
        end
        StPause: ;
        StRing: begin
          if (tick_1hz) begin
            if (ring_last) begin
              ring_cnt_d = '0;
              light_d    = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              wsec_d     = psec_q;
              wmin_d     = pmin_q;
              whour_d    = phour_q;
`endif
            end else begin
              ring_cnt_d = ring_cnt_q + CntW'(1);
              light_d    = (light_q << 1) | (light_q >> (NUM - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    sec_d     = power ? wsec_d : '0;
    min_d     = power ? wmin_d : '0;
    hour_d    = power ? whour_d : '0;
    running_d = (state_d == StRun);
    ring_d    = (state_d == StRing);
  end

  always_ff @(posedge clk_dst or negedge reset_n) begin
    if (!reset_n) begin
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      clear_q    <= 1'b0;
      add_q      <= '0;
      sub_q      <= '0;
      psec_q     <= '0;
      pmin_q     <= '0;
      phour_q    <= '0;
      wsec_q     <= '0;
      wmin_q     <= '0;
      whour_q    <= '0;
      ring_cnt_q <= '0;
      light_q    <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      running_q  <= 1'b0;
      ring_q     <= 1'b0;
    end else begin
      start_q    <= start;
      pause_q    <= pause;
      clear_q    <= clear;
      add_q      <= add_time;
      sub_q      <= sub_time;
      psec_q     <= psec_d;
      pmin_q     <= pmin_d;
      phour_q    <= phour_d;
      wsec_q     <= wsec_d;
      wmin_q     <= wmin_d;
      whour_q    <= whour_d;
      ring_cnt_q <= ring_cnt_d;
      light_q    <= light_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      running_q  <= running_d;
      ring_q     <= ring_d;
    end
  end

  assign sec         = sec_q;
  assign min         = min_q;
  assign hour        = hour_q;
  assign running     = running_q;
  assign alarm_ring  = ring_q;
  assign alarm_light = light_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: seconds-count reference model checked every cycle plus directed literals.
module tb_countdown_timer;
  localparam int unsigned W   = 32;
  localparam int          SR  = 60;
  localparam int          MR  = 60;
  localparam int          HR  = 24;
  localparam int          LEN = 30;
  localparam int          NUM = 5;
  localparam int MSet = 0, MRun = 1, MPause = 2, MRing = 3;

  logic          clk_dst = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick_1hz = 1'b0;
  logic          power = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          clear = 1'b0;
  logic [2:0]    add_time = 3'b000;
  logic [2:0]    sub_time = 3'b000;
  logic [W-1:0]  sec, min, hour;
  logic          running, alarm_ring;
  logic [NUM-1:0] alarm_light;

  int checks = 0;
  int errors = 0;

  countdown_timer #(
    .WIDTH(W), .SEC_RANGE(SR), .MIN_RANGE(MR), .HOUR_RANGE(HR), .LEN(LEN), .NUM(NUM)
  ) dut (
    .clk_dst(clk_dst), .reset_n(reset_n), .tick_1hz(tick_1hz), .power(power),
    .start(start), .pause(pause), .clear(clear), .add_time(add_time), .sub_time(sub_time),
    .sec(sec), .min(min), .hour(hour), .running(running), .alarm_ring(alarm_ring),
    .alarm_light(alarm_light)
  );

  always #5 clk_dst = ~clk_dst;

  // Reference model: working value kept as a plain count of seconds.
  typedef struct {
    int mode; int total; int ps; int pm; int ph; int ring; bit pwr;
    bit st_p; bit pa_p; bit cl_p; logic [2:0] ad_p; logic [2:0] sb_p;
  } model_t;

  model_t m = '{default: 0};

  function automatic int step_field(input int v, input bit up, input bit dn, input int range);
    if (up && !dn) return (v + 1) % range;
    if (dn && !up) return (v + range - 1) % range;
    return v;
  endfunction

  function automatic model_t model_next(input model_t c);
    model_t n = c;
    bit st, pa, cl;
    logic [2:0] ad, sb;
    int pt;
    st = start && !c.st_p;
    pa = pause && !c.pa_p;
    cl = clear && !c.cl_p;
    ad = add_time & ~c.ad_p;
    sb = sub_time & ~c.sb_p;
    n.st_p = start; n.pa_p = pause; n.cl_p = clear; n.ad_p = add_time; n.sb_p = sub_time;
    n.pwr = power;
    pt = c.ph * SR * MR + c.pm * SR + c.ps;
    if (!power || cl) begin
      n.mode = MSet; n.total = pt; n.ring = 0;
    end else begin
      case (c.mode)
        MSet: begin
          if (st) begin
            n.total = pt; n.ring = 0; n.mode = (pt == 0) ? MRing : MRun;
          end else if (ad != 3'b000 || sb != 3'b000) begin
            n.ps = step_field(c.ps, ad[0], sb[0], SR);
            n.pm = step_field(c.pm, ad[1], sb[1], MR);
            n.ph = step_field(c.ph, ad[2], sb[2], HR);
            n.total = n.ph * SR * MR + n.pm * SR + n.ps;
          end
        end
        MRun: begin
          if (pa && !st) n.mode = MPause;
          else if (tick_1hz) begin
            n.total = c.total - 1;
            if (n.total == 0) begin n.mode = MRing; n.ring = 0; end
          end
        end
        MPause: if (st) n.mode = MRun;
        default: begin
          if (tick_1hz) begin
            n.ring = c.ring + 1;
            if (n.ring == LEN) begin
              n.mode = MSet; n.ring = 0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              n.total = pt;
`endif
            end
          end
        end
      endcase
    end
    return n;
  endfunction

  always @(posedge clk_dst or negedge reset_n) begin
    if (!reset_n) m <= '{default: 0};
    else          m <= model_next(m);
  end

  logic [W-1:0]   e_sec, e_min, e_hour;
  logic           e_run, e_ring;
  logic [NUM-1:0] e_light;

  always @(negedge clk_dst) begin
    e_sec   = m.pwr ? W'(m.total % SR) : '0;
    e_min   = m.pwr ? W'((m.total / SR) % MR) : '0;
    e_hour  = m.pwr ? W'(m.total / (SR * MR)) : '0;
    e_run   = (m.mode == MRun);
    e_ring  = (m.mode == MRing);
    e_light = e_ring ? (NUM'(1) << (m.ring % NUM)) : '0;
    checks++;
    if (sec !== e_sec || min !== e_min || hour !== e_hour || running !== e_run ||
        alarm_ring !== e_ring || alarm_light !== e_light) begin
      errors++;
      $display("FAIL model_cmp t=%0t got %0d:%0d:%0d run=%b ring=%b light=%b exp %0d:%0d:%0d run=%b ring=%b light=%b",
               $time, hour, min, sec, running, alarm_ring, alarm_light,
               e_hour, e_min, e_sec, e_run, e_ring, e_light);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_dst);
    #1;
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1; cyc();
    tick_1hz = 1'b0; cyc();
  endtask

  task automatic pulse_adj(input logic [2:0] a, input logic [2:0] s);
    add_time = a; sub_time = s; cyc();
    add_time = 3'b000; sub_time = 3'b000; cyc();
  endtask

  task automatic pulse_ctl(input bit s, input bit p, input bit c);
    start = s; pause = p; clear = c; cyc();
    start = 1'b0; pause = 1'b0; clear = 1'b0; cyc();
  endtask

  initial begin
    cyc(); cyc();
    check("reset_sec", sec, 0);
    check("reset_running", 32'(running), 0);
    check("reset_ring", 32'(alarm_ring), 0);
    check("reset_light", 32'(alarm_light), 0);
    reset_n = 1'b1; cyc();

    // 00:00:03 countdown into ring, then ring exit after LEN ticks
    repeat (3) pulse_adj(3'b001, 3'b000);
    check("preset_sec3", sec, 3);
    pulse_ctl(1, 0, 0);
    do_tick(); check("dec_sec2", sec, 2); check("running", 32'(running), 1);
    do_tick(); check("dec_sec1", sec, 1);
    do_tick(); check("dec_sec0", sec, 0);
    check("ring_on", 32'(alarm_ring), 1); check("light_entry", 32'(alarm_light), 1);
    check("run_off", 32'(running), 0);
    do_tick(); check("light_rot", 32'(alarm_light), 2);
    repeat (28) do_tick();
    check("ring_before_exit", 32'(alarm_ring), 1);
    do_tick();
    check("ring_exit", 32'(alarm_ring), 0); check("light_exit", 32'(alarm_light), 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    check("exit_sec_reload", sec, 3);
`else
    check("exit_sec_zero", sec, 0);
`endif

    // 00:01:00 borrow from minutes
    pulse_ctl(0, 0, 1); check("clear_reload", sec, 3);
    repeat (3) pulse_adj(3'b000, 3'b001);
    pulse_adj(3'b010, 3'b000);
    pulse_ctl(1, 0, 0); do_tick();
    check("borrow_min", min, 0); check("borrow_sec", sec, 59);
    pulse_ctl(0, 0, 1);

    // 01:00:00 borrow from hours
    pulse_adj(3'b000, 3'b010); pulse_adj(3'b100, 3'b000);
    check("preset_hour1", hour, 1);
    pulse_ctl(1, 0, 0); do_tick();
    check("borrow2_hour", hour, 0); check("borrow2_min", min, 59); check("borrow2_sec", sec, 59);
    pulse_ctl(0, 0, 1);

    // 00:00:05 with pause
    pulse_adj(3'b000, 3'b100);
    repeat (5) pulse_adj(3'b001, 3'b000);
    pulse_ctl(1, 0, 0); do_tick(); do_tick();
    pulse_ctl(0, 1, 0);
    repeat (3) do_tick();
    check("paused_sec", sec, 3); check("paused_running", 32'(running), 0);
    pulse_ctl(1, 0, 0); do_tick();
    check("resume_sec", sec, 2);
    pulse_ctl(0, 0, 1); check("clear_sec5", sec, 5);

    // SET-mode field wrap and cancel
    repeat (5) pulse_adj(3'b000, 3'b001);
    pulse_adj(3'b000, 3'b001); check("sec_wrap_down", sec, 59);
    pulse_adj(3'b000, 3'b100); check("hour_wrap_down", hour, 23);
    pulse_adj(3'b100, 3'b000); check("hour_wrap_up", hour, 0);
    pulse_adj(3'b010, 3'b010); check("min_cancel", min, 0);

    // clear beats start during RUN
    pulse_ctl(1, 0, 0); do_tick(); check("run_sec58", sec, 58);
    pulse_ctl(1, 0, 1);
    check("clr_start_sec", sec, 59); check("clr_start_run", 32'(running), 0);

    // power off blanks, ignores edges, keeps preset
    power = 1'b0; cyc(); check("poweroff_sec", sec, 0);
    pulse_adj(3'b001, 3'b000); check("poweroff_edge", sec, 0);
    power = 1'b1; cyc(); check("poweron_sec", sec, 59);

    // zero preset start rings at once; async reset mid-ring
    pulse_adj(3'b001, 3'b000); check("sec_wrap_up", sec, 0);
    pulse_ctl(1, 0, 0); check("zero_start_ring", 32'(alarm_ring), 1);
    do_tick(); do_tick(); check("ring_light4", 32'(alarm_light), 4);
    reset_n = 1'b0; #1;
    check("async_ring", 32'(alarm_ring), 0); check("async_light", 32'(alarm_light), 0);
    check("async_sec", sec, 0); check("async_running", 32'(running), 0);
    cyc(); reset_n = 1'b1; cyc();
    pulse_ctl(1, 0, 0); check("preset_lost_ring", 32'(alarm_ring), 1);
    repeat (3) do_tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
